// File: rtl/sci_pkg.sv
// Shared types and width helpers for the SCI master and its bench.
package sci_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWdata,
        StRdata,
        StResp
    } sci_state_e;

    localparam int unsigned CmdBits = 1;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Serial bits driven by the master: command + address (+ write data).
    function automatic int unsigned write_frame_len(input int unsigned aw, input int unsigned dw);
        return CmdBits + aw + dw;
    endfunction

    function automatic int unsigned read_hdr_len(input int unsigned aw);
        return CmdBits + aw;
    endfunction

endpackage

// File: rtl/sci_shift_reg.sv
// Parallel-load shift register: MSB-first serial out, serial in at the LSB.
module sci_shift_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic [Width-1:0] q_o,
    output logic             sout_o
);

    logic [Width-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[Width-2:0], sin_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o    = sr_q;
    assign sout_o = sr_q[Width-1];

endmodule

// File: rtl/sci_master_v2.sv
// SCI master: serialises single-word read/write requests to one of NUM_PERIPHERALS slaves.
// Define SCI_MASTER_TIMEOUT_EN to add a read watchdog of TIMEOUT_CYCLES clocks.
module sci_master_v2
    import sci_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned NUM_PERIPHERALS = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    localparam int unsigned SEL_W          = sel_width(NUM_PERIPHERALS)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REQ,
    input  logic                       WNR,
    input  logic [ADDR_WIDTH-1:0]      ADDR,
    input  logic [SEL_W-1:0]           PSEL,
    input  logic [DATA_WIDTH-1:0]      DATA_IN,
    output logic                       READY,
    output logic                       ACK,
    output logic                       ERR,
    output logic [DATA_WIDTH-1:0]      DATA_OUT,
    output logic [NUM_PERIPHERALS-1:0] SCI_CSN,
    output logic                       SCI_SOUT,
    input  logic                       SCI_SIN,
    input  logic                       SCI_SACK
);

    localparam int unsigned SrW = max_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned PhW = $clog2(SrW);
    localparam int unsigned BcW = $clog2(DATA_WIDTH + 2);

    sci_state_e state_q, state_d;

    logic                  wnr_q, wnr_d;
    logic [SEL_W-1:0]      psel_q, psel_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [PhW-1:0]        phase_q, phase_d;
    logic [BcW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  sack_q, sack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic accept, psel_ok, addr_last, wdata_last, sack_fall, read_ok, timeout_hit;
    logic tx_load, tx_shift, tx_sout, rx_shift;
    logic [SrW-1:0]        tx_load_val;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [SrW-1:0]        unused_tx_par;
    logic                  unused_rx_sout;

    assign accept     = (state_q == StIdle) && REQ;
    assign psel_ok    = 32'(PSEL) < NUM_PERIPHERALS;
    assign addr_last  = (state_q == StAddr) && (phase_q == '0);
    assign wdata_last = (state_q == StWdata) && (phase_q == '0);
    // sack_q is forced low outside RDATA, so a SACK already high on entry is not a fall.
    assign sack_fall  = (state_q == StRdata) && sack_q && !SCI_SACK;
    assign read_ok    = (bit_cnt_q == BcW'(DATA_WIDTH));

`ifdef SCI_MASTER_TIMEOUT_EN
    localparam int unsigned TwW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TwW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = '0;
        if (state_q == StRdata) begin
            wd_d = wd_q + TwW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_hit = (state_q == StRdata) && (wd_q == TwW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Address is loaded on accept; write data replaces it on the last address bit.
    assign tx_load     = accept || (addr_last && wnr_q);
    assign tx_load_val = accept ? (SrW'(ADDR) << (SrW - ADDR_WIDTH))
                                : (SrW'(wdata_q) << (SrW - DATA_WIDTH));
    assign tx_shift    = (state_q == StAddr) || (state_q == StWdata);
    assign rx_shift    = (state_q == StRdata) && SCI_SACK;

    sci_shift_reg #(
        .Width(SrW)
    ) u_tx (
        .clk_i     (CLK),
        .rst_i     (RST),
        .load_i    (tx_load),
        .load_val_i(tx_load_val),
        .shift_i   (tx_shift),
        .sin_i     (1'b0),
        .q_o       (unused_tx_par),
        .sout_o    (tx_sout)
    );

    sci_shift_reg #(
        .Width(DATA_WIDTH)
    ) u_rx (
        .clk_i     (CLK),
        .rst_i     (RST),
        .load_i    (1'b0),
        .load_val_i('0),
        .shift_i   (rx_shift),
        .sin_i     (SCI_SIN),
        .q_o       (rx_data),
        .sout_o    (unused_rx_sout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = psel_ok ? StCmd : StResp;
            StCmd:   state_d = StAddr;
            StAddr:  if (addr_last) state_d = wnr_q ? StWdata : StRdata;
            StWdata: if (wdata_last) state_d = StResp;
            StRdata: if (sack_fall || timeout_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wnr_d     = wnr_q;
        psel_d    = psel_q;
        wdata_d   = wdata_q;
        phase_d   = phase_q;
        bit_cnt_d = '0;
        sack_d    = 1'b0;
        err_d     = 1'b0;
        dout_d    = dout_q;
        if (accept) begin
            wnr_d   = WNR;
            psel_d  = PSEL;
            wdata_d = DATA_IN;
            err_d   = !psel_ok;
        end
        unique case (state_q)
            StCmd:   phase_d = PhW'(ADDR_WIDTH - 1);
            StAddr:  phase_d = addr_last ? PhW'(DATA_WIDTH - 1) : phase_q - PhW'(1);
            StWdata: if (!wdata_last) phase_d = phase_q - PhW'(1);
            StRdata: begin
                sack_d    = SCI_SACK;
                bit_cnt_d = bit_cnt_q;
                if (SCI_SACK && (bit_cnt_q != BcW'(DATA_WIDTH + 1))) begin
                    bit_cnt_d = bit_cnt_q + BcW'(1);
                end
                // A fall in the same cycle as the watchdog takes priority.
                if (sack_fall) begin
                    err_d = !read_ok;
                    if (read_ok) dout_d = rx_data;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wnr_q     <= 1'b0;
            psel_q    <= '0;
            wdata_q   <= '0;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            sack_q    <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            wnr_q     <= wnr_d;
            psel_q    <= psel_d;
            wdata_q   <= wdata_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            sack_q    <= sack_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
        end
    end

    always_comb begin
        READY    = (state_q == StIdle);
        ACK      = (state_q == StResp);
        ERR      = err_q;
        DATA_OUT = dout_q;
        SCI_SOUT = 1'b0;
        SCI_CSN  = '1;
        unique case (state_q)
            StCmd:           SCI_SOUT = wnr_q;
            StAddr, StWdata: SCI_SOUT = tx_sout;
            default: ;
        endcase
        if (state_q inside {StCmd, StAddr, StWdata, StRdata}) begin
            for (int unsigned i = 0; i < NUM_PERIPHERALS; i++) begin
                if (32'(psel_q) == i) SCI_CSN[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sci_master_v2.sv
// Scoreboard bench for sci_master_v2 (3 peripherals so an out-of-range PSEL is reachable).
// Define SCI_MASTER_TIMEOUT_EN for both bench and RTL to cover the read watchdog.
module tb_sci_master_v2;
    import sci_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned NP = 3;
    localparam int unsigned TO = 16;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          wnr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [SW-1:0] psel = '0;
    logic [DW-1:0] din = '0;
    logic          sin = 1'b0;
    logic          sack = 1'b0;
    logic          ready, ack, err, sout;
    logic [DW-1:0] dout;
    logic [NP-1:0] csn;

    typedef struct {
        logic          err;
        logic [DW-1:0] dout;
        logic [15:0]   frame;
        int            len;
        int unsigned   ack_cyc;
        logic [NP-1:0] csn;
    } exp_t;

    exp_t          exp_q[$];
    bit            sout_bits[$];
    logic [DW-1:0] model_dout = '0;
    int unsigned   cyc = 0;
    int            n_vec = 0;
    int            n_fail = 0;

    sci_master_v2 #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_PERIPHERALS(NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .WNR     (wnr),
        .ADDR    (addr),
        .PSEL    (psel),
        .DATA_IN (din),
        .READY   (ready),
        .ACK     (ack),
        .ERR     (err),
        .DATA_OUT(dout),
        .SCI_CSN (csn),
        .SCI_SOUT(sout),
        .SCI_SIN (sin),
        .SCI_SACK(sack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: collects the serial frame while a select is low, scores each ACK.
    logic [NP-1:0] csn_seen;
    bit            csn_mixed;
    bit            ready_chk;
    exp_t          e_mon;
    logic [15:0]   obs_frame;
    bit            tail_bad;

    always @(negedge clk) begin
        if (rst) begin
            sout_bits.delete();
            csn_seen  = {NP{1'b1}};
            csn_mixed = 1'b0;
            ready_chk = 1'b0;
        end else begin
            if (ready_chk) begin
                check_eq("ready_after_resp", ready, 1);
                ready_chk = 1'b0;
            end
            if (csn != {NP{1'b1}}) begin
                sout_bits.push_back(sout);
                if (csn_seen != {NP{1'b1}} && csn != csn_seen) csn_mixed = 1'b1;
                csn_seen = csn;
            end
            if (ack) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ack", 1, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    obs_frame = '0;
                    tail_bad  = 1'b0;
                    for (int i = 0; i < sout_bits.size(); i++) begin
                        if (i < e_mon.len) obs_frame = {obs_frame[14:0], sout_bits[i]};
                        else if (sout_bits[i]) tail_bad = 1'b1;
                    end
                    check_eq("ack_cycle", cyc, e_mon.ack_cyc);
                    check_eq("err", err, e_mon.err);
                    check_eq("data_out", dout, e_mon.dout);
                    check_eq("frame", obs_frame, e_mon.frame);
                    check_eq("frame_bits", 32'(sout_bits.size() >= e_mon.len), 1);
                    check_eq("sout_tail_zero", tail_bad, 0);
                    check_eq("csn_select", csn_seen, e_mon.csn);
                    check_eq("csn_stable", csn_mixed, 0);
                    check_eq("csn_at_ack", csn, {NP{1'b1}});
                    check_eq("sout_at_ack", sout, 0);
                    check_eq("ready_at_ack", ready, 0);
                end
                sout_bits.delete();
                csn_seen  = {NP{1'b1}};
                csn_mixed = 1'b0;
                ready_chk = 1'b1;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!ready && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!ready) check_eq(tag, 0, 1);
    endtask

    task automatic start_req(input logic w, input logic [AW-1:0] a, input logic [SW-1:0] p,
                             input logic [DW-1:0] d, output int unsigned acc);
        wait_ready("ready_before_req");
        req  = 1'b1;
        wnr  = w;
        addr = a;
        psel = p;
        din  = d;
        @(posedge clk);
        #1;
        acc = cyc;
        req = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [SW-1:0] p,
                            input logic [DW-1:0] d, output int unsigned acc);
        exp_t e;
        start_req(1'b1, a, p, d, acc);
        e.dout = model_dout;
        if (32'(p) < NP) begin
            e.err     = 1'b0;
            e.frame   = 16'({1'b1, a, d});
            e.len     = write_frame_len(AW, DW);
            e.ack_cyc = acc + write_frame_len(AW, DW);
            e.csn     = ~(NP'(1) << p);
        end else begin
            e.err     = 1'b1;
            e.frame   = '0;
            e.len     = 0;
            e.ack_cyc = acc;
            e.csn     = {NP{1'b1}};
        end
        exp_q.push_back(e);
    endtask

    // Peripheral model: raise SACK `delay` cycles into RDATA, shift n bits of pat MSB first.
    task automatic do_read(input logic [AW-1:0] a, input logic [SW-1:0] p,
                           input logic [15:0] pat, input int n, input int delay);
        exp_t        e;
        int unsigned acc;
        start_req(1'b0, a, p, '0, acc);
        e.err = (n != DW);
        if (!e.err) model_dout = pat[DW-1:0];
        e.dout    = model_dout;
        e.frame   = 16'({1'b0, a});
        e.len     = read_hdr_len(AW);
        e.ack_cyc = acc + read_hdr_len(AW) + delay + n + 1;
        e.csn     = ~(NP'(1) << p);
        exp_q.push_back(e);
        while (cyc < acc + read_hdr_len(AW) + delay) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < n; i++) begin
            sack = 1'b1;
            sin  = pat[n-1-i];
            @(posedge clk);
            #1;
        end
        sack = 1'b0;
        sin  = 1'b0;
        wait_ready("read_done");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not end, got cycle %0d", cyc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int unsigned acc;
        exp_t        e;

        wait_cycles(3);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_csn", csn, {NP{1'b1}});
        check_eq("rst_sout", sout, 0);
        rst = 1'b0;
        wait_cycles(2);
        check_eq("idle_ready", ready, 1);

        // Basic write, with a REQ pulse while busy that must be dropped.
        do_write(4'hA, 2'd1, 8'h5C, acc);
        wait_cycles(2);
        req  = 1'b1;
        wnr  = 1'b0;
        addr = 4'h5;
        psel = 2'd0;
        din  = 8'h33;
        wait_cycles(1);
        check_eq("busy_ready", ready, 0);
        req = 1'b0;

        do_read(4'h3, 2'd0, 16'h00A5, 8, 3);
        do_read(4'h9, 2'd2, 16'h001B, 5, 1);
        do_read(4'h1, 2'd1, 16'h02D3, 10, 2);
        do_write(4'h2, 2'd3, 8'h11, acc);

        // Back-to-back writes on different selects.
        do_write(4'h0, 2'd2, 8'hFF, acc);
        do_write(4'hF, 2'd0, 8'h00, acc);
        do_read(4'hC, 2'd1, 16'h003C, 8, 0);

        // Reset during write-data bit 4 aborts with no ACK.
        do_write(4'h6, 2'd2, 8'h96, acc);
        while (cyc < acc + read_hdr_len(AW) + 4) begin
            @(posedge clk);
            #1;
        end
        check_eq("csn_before_rst", csn, 3'b011);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_csn", csn, {NP{1'b1}});
        check_eq("abort_ready", ready, 1);
        check_eq("abort_ack", ack, 0);
        exp_q.delete();
        model_dout = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(20);
        do_write(4'h5, 2'd1, 8'hC3, acc);

        // Read with SACK never asserted.
        start_req(1'b0, 4'h7, 2'd1, '0, acc);
`ifdef SCI_MASTER_TIMEOUT_EN
        e.err     = 1'b1;
        e.dout    = model_dout;
        e.frame   = 16'({1'b0, 4'h7});
        e.len     = read_hdr_len(AW);
        e.ack_cyc = acc + read_hdr_len(AW) + TO;
        e.csn     = 3'b101;
        exp_q.push_back(e);
        wait_ready("timeout_ack");
`else
        e.err = 1'b0;
        wait_cycles(1000);
        check_eq("stuck_ready", ready, 0);
        check_eq("stuck_csn", csn, 3'b101);
        rst = 1'b1;
        #1;
        check_eq("recover_ready", ready, 1);
        check_eq("recover_csn", csn, {NP{1'b1}});
        model_dout = '0;
        @(posedge clk);
        #1 rst = 1'b0;
`endif
        wait_cycles(5);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
